ice_bus_slave_buffer: RTL and testbench

Per-device outbound frame buffer feeding the ICE bus controller's slave-side read port. A local producer (I2C/GPIO/MBus handler) pushes response frames byte by byte. The block stores them in a 512-entry circular buffer of 9-bit words, where bit 8 marks the last byte of a frame. It raises an arbitration request while at least one complete frame is held, and serves asynchronous reads at the controller's `sl_addr` until the controller latches a new tail.

---
 rtl/ice_bus_slave_buffer_if.sv | 52 +++++
 rtl/ice_bus_slave_buffer.sv | 164 ++++++++++++++++
 tb/tb_ice_bus_slave_buffer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ice_bus_slave_buffer_if.sv
// ice_bus_slave_buffer_if: producer and controller-facing signals of the ICE
// bus slave buffer. The master modport is the producer/controller side and the
// slave modport is the buffer itself.
interface ice_bus_slave_buffer_if #(
    parameter int unsigned ADDR_W = 9
);
    // producer side
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_abort;
    logic              in_ready;
    logic              overflow;

    // controller read port
    logic [ADDR_W-1:0] sl_addr;
    logic [ADDR_W-1:0] sl_data;
    logic [ADDR_W-1:0] sl_tail;
    logic              sl_latch_tail;
    logic              sl_arb_request;
    logic              sl_arb_grant;

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        input  in_abort,
        output in_ready,
        output overflow,
        input  sl_addr,
        output sl_data,
        output sl_tail,
        input  sl_latch_tail,
        output sl_arb_request,
        input  sl_arb_grant
    );

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        output in_abort,
        input  in_ready,
        input  overflow,
        output sl_addr,
        input  sl_data,
        input  sl_tail,
        output sl_latch_tail,
        input  sl_arb_request,
        output sl_arb_grant
    );
endinterface

// File: rtl/ice_bus_slave_buffer.sv
// ice_bus_slave_buffer: per-device outbound frame buffer for the ICE bus
// controller's slave read port. Bytes are pushed by a local producer into a
// circular buffer of 9-bit words ({last_flag, byte}); complete frames raise
// sl_arb_request and are read combinationally at sl_addr until the controller
// latches a new tail. One entry is always kept empty.
// Optional feature: define ICE_SLAVE_BUFFER_ABORT_EN to let in_abort discard
// the frame in progress; otherwise in_abort is ignored.
module ice_bus_slave_buffer #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    ice_bus_slave_buffer_if.slave bus
);

    localparam int unsigned       DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] head_next;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W-1:0] tail_next;
    logic [ADDR_W-1:0] frame_cnt;
    logic [ADDR_W-1:0] frame_cnt_next;

    logic [8:0]        mem [DEPTH];

    logic [ADDR_W-1:0] free;
    logic              space;
    logic              ready;
    logic              wr_en;
    logic              commit;
    logic              latch_ok;
    logic              ovf_evt;
    logic              overflow_q;
    logic              abort_req;

    logic              unused_grant;
    assign unused_grant = bus.sl_arb_grant;

`ifdef ICE_SLAVE_BUFFER_ABORT_EN
    assign abort_req = bus.in_abort;
`else
    logic unused_abort;
    assign unused_abort = bus.in_abort;
    assign abort_req    = 1'b0;
`endif

    // Free space between the write pointer and the tail, keeping one slot empty.
    assign free     = tail - wr_ptr - ONE;
    assign space    = (free != '0);
    assign latch_ok = bus.sl_latch_tail && (frame_cnt != '0);

    // Next-state, pointer and write-enable decode for the producer side.
    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        head_next   = head;
        ready       = 1'b1;
        wr_en       = 1'b0;
        commit      = 1'b0;
        ovf_evt     = 1'b0;

        case (state)
            IDLE, FILL: begin
                ready = space;
                if (abort_req && (state == FILL)) begin
                    // Abort beats a same-cycle byte and never pulses overflow.
                    wr_ptr_next = head;
                    state_next  = IDLE;
                end else if (bus.in_valid) begin
                    if (space) begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr + ONE;
                        if (bus.in_last) begin
                            head_next  = wr_ptr + ONE;
                            commit     = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = FILL;
                        end
                    end else begin
                        // Full: rewind to the last commit point and drop the frame.
                        ovf_evt     = 1'b1;
                        wr_ptr_next = head;
                        state_next  = bus.in_last ? IDLE : DROP;
                    end
                end
            end

            DROP: begin
                if (abort_req) begin
                    state_next = IDLE;
                end else if (bus.in_valid && bus.in_last) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read-side tail and frame count; a commit and a latch in one cycle cancel.
    always_comb begin
        tail_next      = latch_ok ? bus.sl_addr : tail;
        frame_cnt_next = frame_cnt;
        case ({commit, latch_ok})
            2'b10:   frame_cnt_next = frame_cnt + ONE;
            2'b01:   frame_cnt_next = frame_cnt - ONE;
            default: frame_cnt_next = frame_cnt;
        endcase
    end

    // State and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            head       <= '0;
            tail       <= '0;
            frame_cnt  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_ptr_next;
            head       <= head_next;
            tail       <= tail_next;
            frame_cnt  <= frame_cnt_next;
            overflow_q <= ovf_evt;
        end
    end

    // Buffer storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {bus.in_last, bus.in_data};
        end
    end

    assign bus.in_ready       = ready;
    assign bus.overflow       = overflow_q;
    assign bus.sl_data        = ADDR_W'(mem[bus.sl_addr]);
    assign bus.sl_tail        = tail;
    assign bus.sl_arb_request = (frame_cnt != '0);

    // Outside a partial frame the write pointer always sits at the commit point.
    a_ptr_at_head: assert property (
        @(posedge clk) disable iff (rst) (state != FILL) |-> (wr_ptr == head)
    );

endmodule

// File: tb/tb_ice_bus_slave_buffer.sv
// tb_ice_bus_slave_buffer: directed stimulus for ice_bus_slave_buffer, checked
// every cycle against a byte-queue model of the buffer plus literal checks.
module tb_ice_bus_slave_buffer;

    localparam int unsigned ADDR_W = 9;
    localparam int          DEPTH  = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ice_bus_slave_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    ice_bus_slave_buffer #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: committed bytes live between m_tail and m_head; the frame in
    // progress is a queue that is copied into the model memory on its last byte.
    logic [8:0] m_mem [DEPTH];
    logic [8:0] m_pend [$];
    int         m_head = 0;
    int         m_tail = 0;
    int         m_cnt  = 0;
    bit         m_drop = 0;
    bit         m_ovf  = 0;
    bit         m_live = 0;

    function automatic int m_free();
        return (DEPTH - 1) - (((m_head - m_tail) % DEPTH + DEPTH) % DEPTH) - m_pend.size();
    endfunction

    always @(posedge clk) begin : model
        int  fr;
        int  n;
        bit  commit;
        bit  latch;
        bit  aborting;
        bit  ovf_n;
        if (rst) begin
            m_head = 0;
            m_tail = 0;
            m_cnt  = 0;
            m_drop = 0;
            m_ovf  = 0;
            m_pend.delete();
            m_live = 1;
        end else begin
            fr     = m_free();
            commit = 0;
            latch  = 0;
            ovf_n  = 0;
`ifdef ICE_SLAVE_BUFFER_ABORT_EN
            aborting = bus.in_abort && (m_drop || m_pend.size() != 0);
`else
            aborting = 0;
`endif
            if (aborting) begin
                m_pend.delete();
                m_drop = 0;
            end else if (bus.in_valid) begin
                if (m_drop) begin
                    if (bus.in_last) m_drop = 0;
                end else if (fr == 0) begin
                    ovf_n = 1;
                    m_pend.delete();
                    m_drop = !bus.in_last;
                end else begin
                    m_pend.push_back({bus.in_last, bus.in_data});
                    if (bus.in_last) begin
                        n = m_pend.size();
                        for (int k = 0; k < n; k++) m_mem[(m_head + k) % DEPTH] = m_pend[k];
                        m_head = (m_head + n) % DEPTH;
                        m_pend.delete();
                        commit = 1;
                    end
                end
            end
            if (bus.sl_latch_tail && m_cnt != 0) begin
                m_tail = int'(bus.sl_addr);
                latch  = 1;
            end
            m_cnt = m_cnt + int'(commit) - int'(latch);
            m_ovf = ovf_n;
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin : compare
        int a;
        int used;
        if (m_live) begin
            check("in_ready", int'(bus.in_ready), int'(m_drop || m_free() != 0));
            check("overflow", int'(bus.overflow), int'(m_ovf));
            check("sl_arb_request", int'(bus.sl_arb_request), int'(m_cnt != 0));
            check("sl_tail", int'(bus.sl_tail), m_tail);
            a    = int'(bus.sl_addr);
            used = ((m_head - m_tail) % DEPTH + DEPTH) % DEPTH;
            if ((((a - m_tail) % DEPTH + DEPTH) % DEPTH) < used)
                check("sl_data", int'(bus.sl_data), int'(m_mem[a]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic latch(input int addr);
        bus.sl_addr       = ADDR_W'(addr);
        bus.sl_latch_tail = 1'b1;
        tick();
        bus.sl_latch_tail = 1'b0;
    endtask

    task automatic peek(input string name, input int addr, input int exp);
        bus.sl_addr = ADDR_W'(addr);
        tick();
        check(name, int'(bus.sl_data), exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data       = '0;
        bus.in_valid      = 1'b0;
        bus.in_last       = 1'b0;
        bus.in_abort      = 1'b0;
        bus.sl_addr       = '0;
        bus.sl_latch_tail = 1'b0;
        bus.sl_arb_grant  = 1'b0;

        // Reset values and a single 3-byte frame.
        do_reset();
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_request", int'(bus.sl_arb_request), 0);
        check("rst_tail", int'(bus.sl_tail), 0);
        push(8'h41, 1'b0);
        push(8'h07, 1'b0);
        check("req_before_last", int'(bus.sl_arb_request), 0);
        push(8'h02, 1'b1);
        check("req_after_last", int'(bus.sl_arb_request), 1);
        peek("f1_b0", 0, 9'h041);
        peek("f1_b1", 1, 9'h007);
        peek("f1_b2", 2, 9'h102);
        latch(3);
        check("f1_tail", int'(bus.sl_tail), 3);
        check("f1_req_drop", int'(bus.sl_arb_request), 0);

        // Frame counting, including a commit coinciding with a latch.
        do_reset();
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b1);
        push(8'hB1, 1'b1);
        latch(2);
        check("cnt_2to1_req", int'(bus.sl_arb_request), 1);
        check("cnt_2to1_tail", int'(bus.sl_tail), 2);
        push(8'hC1, 1'b0);
        bus.in_valid      = 1'b1;
        bus.in_data       = 8'hC2;
        bus.in_last       = 1'b1;
        bus.sl_addr       = ADDR_W'(3);
        bus.sl_latch_tail = 1'b1;
        tick();
        bus.in_valid      = 1'b0;
        bus.in_last       = 1'b0;
        bus.sl_latch_tail = 1'b0;
        check("simul_req", int'(bus.sl_arb_request), 1);
        check("simul_tail", int'(bus.sl_tail), 3);
        latch(5);
        check("last_latch_req", int'(bus.sl_arb_request), 0);
        latch(100);
        check("empty_latch_tail", int'(bus.sl_tail), 5);

        // Fill to capacity, overflow, drop the remainder, then store normally.
        do_reset();
        for (int i = 0; i < 511; i++) push(8'(i), 1'b0);
        check("full_ready", int'(bus.in_ready), 0);
        push(8'hEE, 1'b0);
        check("ovf_pulse", int'(bus.overflow), 1);
        check("drop_ready", int'(bus.in_ready), 1);
        push(8'hD0, 1'b0);
        check("ovf_one_cycle", int'(bus.overflow), 0);
        push(8'hD1, 1'b0);
        push(8'hD2, 1'b1);
        check("drop_no_req", int'(bus.sl_arb_request), 0);
        push(8'h55, 1'b0);
        push(8'hAA, 1'b1);
        peek("post_drop_b0", 0, 9'h055);
        peek("post_drop_b1", 1, 9'h1AA);
        check("post_drop_req", int'(bus.sl_arb_request), 1);

        // Frame straddling the top of the address space.
        do_reset();
        for (int i = 0; i < 510; i++) push(8'(i), (i == 509) ? 1'b1 : 1'b0);
        latch(510);
        check("wrap_pre_tail", int'(bus.sl_tail), 510);
        push(8'h10, 1'b0);
        push(8'h11, 1'b0);
        push(8'h12, 1'b0);
        push(8'h13, 1'b1);
        peek("wrap_510", 510, 9'h010);
        peek("wrap_511", 511, 9'h011);
        peek("wrap_0", 0, 9'h012);
        peek("wrap_1", 1, 9'h113);
        latch(2);
        check("wrap_tail", int'(bus.sl_tail), 2);
        check("wrap_req", int'(bus.sl_arb_request), 0);

        // Abort of a partial frame.
        do_reset();
        push(8'h21, 1'b0);
        push(8'h22, 1'b0);
        bus.in_abort = 1'b1;
        tick();
        bus.in_abort = 1'b0;
        check("abort_no_req", int'(bus.sl_arb_request), 0);
        push(8'h77, 1'b1);
        check("abort_next_req", int'(bus.sl_arb_request), 1);
`ifdef ICE_SLAVE_BUFFER_ABORT_EN
        peek("abort_restart", 0, 9'h177);
`else
        peek("abort_ignored_b0", 0, 9'h021);
        peek("abort_ignored_b2", 2, 9'h177);
`endif

        // Reset in the middle of a frame with a frame held.
        do_reset();
        push(8'h30, 1'b1);
        push(8'h31, 1'b1);
        latch(1);
        push(8'h32, 1'b0);
        push(8'h33, 1'b0);
        check("pre_rst_tail", int'(bus.sl_tail), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_tail", int'(bus.sl_tail), 0);
        check("mid_rst_req", int'(bus.sl_arb_request), 0);
        check("mid_rst_ready", int'(bus.in_ready), 1);
        push(8'h44, 1'b1);
        peek("mid_rst_restart", 0, 9'h144);

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
